// File: rtl/traffic_engine.sv
// traffic_engine: obstacle-car motion, spawning, scoring, levels and game-state control.
// Car positions are packed per car for the sprite renderer; score/level feed the HUD.
module traffic_engine #(
    parameter int NUM_CARS = 6,
    parameter int NUM_LANES = 3,
    parameter logic [NUM_LANES*10-1:0] LANE_X = {10'd410, 10'd290, 10'd170},
    parameter int SCREEN_H = 480,
    parameter int STEP = 4,
    parameter int SPAWN_GAP = 100,
    parameter int TICK_DIV = 200000,
    parameter int SCORE_W = 7,
    parameter int LVL1 = 11,
    parameter int LVL2 = 21,
    parameter int LVL3 = 36,
    parameter int SPD0 = 8,
    parameter int SPD1 = 6,
    parameter int SPD2 = 4,
    parameter int SPD3 = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    collision,
    output logic [NUM_CARS*10-1:0]  car_x,
    output logic [NUM_CARS*10-1:0]  car_y,
    output logic [NUM_CARS-1:0]     car_active,
    output logic [SCORE_W-1:0]      score,
    output logic [1:0]              level,
    output logic [1:0]              game_state,
    output logic                    move_tick
);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int SMAX = (1 << SCORE_W) - 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;

    state_t               state, state_nx;
    logic [DW-1:0]        div;
    logic [15:0]          presc, spd;
    logic                 base_tick, clear, upd;
    logic [NUM_CARS-1:0]  wrap, gap;
    logic [3:0]           wraps;
    logic [31:0]          tot;
    logic [SCORE_W-1:0]   score_nx;
    logic [1:0]           level_nx;

    function automatic logic [9:0] lane_x(input int l);
        return LANE_X[l*10+:10];
    endfunction

    assign base_tick = div == DW'(TICK_DIV - 1);
    assign spd = level == 2'd0 ? 16'(SPD0) : level == 2'd1 ? 16'(SPD1) :
                 level == 2'd2 ? 16'(SPD2) : 16'(SPD3);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) div <= '0;
        else div <= base_tick ? '0 : div + 1'b1;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, OVER: if (start) state_nx = RUN;
            RUN:        if (collision) state_nx = OVER; else if (pause) state_nx = PAUSE;
            PAUSE:      if (!pause) state_nx = RUN;
        endcase
    end

    // A collision in the same cycle as a move discards that move entirely.
    always_comb begin
        clear = (state == IDLE || state == OVER) && start;
        move_tick = state == RUN && base_tick && presc >= spd;
        upd = move_tick && !collision;
        game_state = state;
    end

    // Prescaler runs 1..spd; >= lets a lowered spd take effect on the next base tick.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) presc <= '0;
        else if (clear) presc <= '0;
        else if (state == RUN && base_tick) presc <= move_tick ? 16'd1 : presc + 16'd1;

    always_comb begin
        wraps = '0;
        for (int i = 0; i < NUM_CARS; i++) wraps = wraps + 4'(wrap[i]);
        tot = 32'(score) + 32'(wraps);
        score_nx = tot > 32'(SMAX) ? SCORE_W'(SMAX) : tot[SCORE_W-1:0];
        level_nx = 32'(score) >= 32'(LVL3) ? 2'd3 : 32'(score) >= 32'(LVL2) ? 2'd2 :
                   32'(score) >= 32'(LVL1) ? 2'd1 : 2'd0;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            score <= '0;
            level <= '0;
        end else if (clear) begin
            score <= '0;
            level <= '0;
        end else if (state == RUN) begin
            if (upd) score <= score_nx;
            level <= level_nx;
        end

    for (genvar c = 0; c < NUM_CARS; c++) begin : g_car
        logic [9:0]    x, y;
        logic [10:0]   sum;
        logic [LW-1:0] lane, lane_nx;
        logic          act;
        // gap[c] is the spawn permission for car c, produced by car c-1.
        if (c == 0) begin : g_first
            assign gap[0] = 1'b1;
        end
        if (c < NUM_CARS - 1) begin : g_gap
            assign gap[c+1] = act && y >= 10'(SPAWN_GAP);
        end
        assign sum = {1'b0, y} + 11'(STEP);
        assign wrap[c] = act && sum > 11'(SCREEN_H);
        assign lane_nx = lane == LW'(NUM_LANES - 1) ? '0 : lane + 1'b1;
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                act <= 1'b0;
                y <= '0;
                lane <= LW'(c % NUM_LANES);
                x <= lane_x(c % NUM_LANES);
            end else if (clear) begin
                act <= 1'b0;
                y <= '0;
                lane <= LW'(c % NUM_LANES);
                x <= lane_x(c % NUM_LANES);
            end else if (upd) begin
                act <= act || gap[c];
                if (act) begin
                    y <= wrap[c] ? '0 : sum[9:0];
                    if (wrap[c]) begin
                        lane <= lane_nx;
                        x <= lane_x(int'(lane_nx));
                    end
                end
            end
        assign car_x[c*10+:10] = x;
        assign car_y[c*10+:10] = y;
        assign car_active[c] = act;
    end
endmodule

// File: tb/tb_traffic_engine.sv
// tb_traffic_engine: directed test of traffic_engine with hand-computed expectations.
// A second small instance (2 cars, 3-bit score) covers score saturation.
module tb_traffic_engine;
    logic        clk = 1'b0;
    logic        reset_n, start, start2, pause, collision;
    logic [59:0] car_x, car_y;
    logic [5:0]  car_active;
    logic [6:0]  score;
    logic [1:0]  level, game_state;
    logic        move_tick;
    logic [19:0] car_x2, car_y2;
    logic [1:0]  act2, level2, state2;
    logic [2:0]  score2;
    logic        mt2;
    int checks = 0, failures = 0, km = 0, ks = 0, per = 0, seen = 0;

    always #5 clk = ~clk;

    traffic_engine #(.TICK_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .collision(collision),
        .car_x(car_x), .car_y(car_y), .car_active(car_active), .score(score),
        .level(level), .game_state(game_state), .move_tick(move_tick)
    );

    traffic_engine #(.NUM_CARS(2), .SCREEN_H(20), .SPAWN_GAP(8), .TICK_DIV(4), .SCORE_W(3)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start2), .pause(pause), .collision(collision),
        .car_x(car_x2), .car_y(car_y2), .car_active(act2), .score(score2),
        .level(level2), .game_state(state2), .move_tick(mt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [59:0] p6(input int v0, v1, v2, v3, v4, v5);
        return {10'(v5), 10'(v4), 10'(v3), 10'(v2), 10'(v1), 10'(v0)};
    endfunction

    // Waits (bounded) for a move_tick; with adv, steps one more cycle so outputs show the update.
    task automatic step(input bit s, input bit adv);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(s ? mt2 : move_tick) && c < 200);
        if (c >= 200) chk("move_timeout", s ? mt2 : move_tick, 1);
        per = c + 1;
        if (s) ks++; else km++;
        if (adv) @(negedge clk);
    endtask

    task automatic run_to(input bit s, input int k);
        while ((s ? ks : km) < k) step(s, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; start2 = 1'b0; pause = 1'b0; collision = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", game_state, 0);
        chk("rst_score", score, 0);
        chk("rst_level", level, 0);
        chk("rst_active", car_active, 0);
        chk("rst_y", car_y, 0);
        chk("rst_x", car_x, p6(170, 290, 410, 170, 290, 410));
        chk("rst_tick", move_tick, 0);
        reset_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_state", game_state, 1);

        step(1'b0, 1'b1);
        chk("m1_active", car_active, 6'b000001);
        chk("m1_y", car_y, 0);
        step(1'b0, 1'b1);
        chk("m2_y0", car_y[9:0], 4);
        chk("period_l0", per, 32);

        run_to(1'b0, 26);
        chk("m26_y0", car_y[9:0], 100);
        chk("m26_active", car_active, 6'b000001);
        step(1'b0, 1'b1);
        chk("m27_active", car_active, 6'b000011);
        chk("m27_y1", car_y[19:10], 0);
        chk("m27_y0", car_y[9:0], 104);
        step(1'b0, 1'b1);
        chk("m28_y1", car_y[19:10], 4);
        chk("m28_y0", car_y[9:0], 108);

        run_to(1'b0, 121);
        chk("m121_y0", car_y[9:0], 480);
        chk("m121_x0", car_x[9:0], 170);
        chk("m121_score", score, 0);
        step(1'b0, 1'b1);
        chk("wrap_y0", car_y[9:0], 0);
        chk("wrap_x0", car_x[9:0], 290);
        chk("wrap_score", score, 1);

        run_to(1'b0, 346);
        chk("m346_score", score, 10);
        chk("m346_level", level, 0);
        step(1'b0, 1'b1);
        chk("m347_score", score, 11);
        chk("m347_level_lag", level, 0);
        @(negedge clk);
        chk("m347_level", level, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("period_l1", per, 24);

        run_to(1'b0, 364);
        chk("m364_y", car_y, p6(0, 380, 276, 172, 68, 448));
        chk("m364_x", car_x, p6(170, 170, 290, 410, 170, 170));
        chk("m364_score", score, 12);
        chk("m364_active", car_active, 6'b111111);

        pause = 1'b1;
        @(negedge clk);
        chk("pause_state", game_state, 2);
        seen = 0;
        repeat (1000) begin
            @(negedge clk);
            if (move_tick) seen++;
        end
        chk("pause_no_tick", seen, 0);
        chk("pause_y", car_y, p6(0, 380, 276, 172, 68, 448));
        chk("pause_x", car_x, p6(170, 170, 290, 410, 170, 170));
        chk("pause_score", score, 12);
        pause = 1'b0;
        @(negedge clk);
        chk("resume_state", game_state, 1);
        step(1'b0, 1'b1);
        chk("m365_y0", car_y[9:0], 4);
        chk("m365_y1", car_y[19:10], 384);

        step(1'b0, 1'b0);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        chk("over_state", game_state, 3);
        chk("over_y0", car_y[9:0], 4);
        chk("over_y1", car_y[19:10], 384);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (move_tick) seen++;
        end
        chk("over_no_tick", seen, 0);
        chk("over_score", score, 12);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_state", game_state, 1);
        chk("restart_score", score, 0);
        chk("restart_level", level, 0);
        chk("restart_active", car_active, 0);
        chk("restart_y", car_y, 0);
        chk("restart_x", car_x, p6(170, 290, 410, 170, 290, 410));

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("sat_state", state2, 1);
        run_to(1'b1, 22);
        chk("sat_m22", score2, 6);
        run_to(1'b1, 25);
        chk("sat_m25", score2, 7);
        run_to(1'b1, 31);
        chk("sat_m31", score2, 7);
        chk("sat_active", act2, 2'b11);

        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", game_state, 0);
        chk("arst_score", score, 0);
        chk("arst_active", car_active, 0);
        chk("arst_y", car_y, 0);
        chk("arst_state_s", state2, 0);
        chk("arst_score_s", score2, 0);
        #10 reset_n = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
